// File: rtl/cpu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_pkg : shared widths, reset PC and fetch-entry type                |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package cpu_pkg;

  localparam int              XLEN        = 32;
  localparam logic [XLEN-1:0] RESET_PC    = 32'h0000_0000;
  localparam int              INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instructions are word aligned; the low address bits are simply dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fetch_skid_buf : 2-entry FIFO of fetch entries with flush             |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module fetch_skid_buf
  import cpu_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  localparam logic [1:0] C_FULL = 2'(BUF_DEPTH);

  fetch_entry_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  logic w_push;
  logic w_pop;

  // Pointers alone cannot tell full from empty, so occupancy lives in r_count.
  assign w_push = push_i && !flush_i && (r_count != C_FULL);
  assign w_pop  = pop_i  && !flush_i && (r_count != 2'd0);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data_i;
  end

  assign count_o = r_count;
  assign head_o  = (r_count == 2'd0) ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | instr_fetch : PC, imem request/credit logic, redirect and skid buffer |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int              XLEN      = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_tgt_i,
  input  logic            ready_i,
  output logic            imem_en_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] addr_o
);

  logic [XLEN-1:0] r_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;

  logic [1:0]      w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;
  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic [2:0]      w_credit;
  logic            w_issue;
  logic [XLEN-1:0] w_fetch_addr;

  assign w_valid = (w_count != 2'd0) && !redirect_i;
  assign w_pop   = w_valid && ready_i;
  assign w_push  = r_inflight && !redirect_i;

  // Slots already promised: buffered words plus the word still in flight.
  assign w_credit = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  // Reset gates the request so imem never sees a fetch while held in reset.
  assign w_issue      = !rst_n && (redirect_i || (w_credit < 3'd2));
  assign w_fetch_addr = redirect_i ? align_pc(redirect_tgt_i) : r_pc;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc          <= w_fetch_addr + XLEN'(INSTR_BYTES);
        r_inflight_pc <= w_fetch_addr;
      end
    end
  end

  assign w_push_data.instr = imem_rdata_i;
  assign w_push_data.pc    = r_inflight_pc;

  fetch_skid_buf #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_skid_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_i),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (w_pop),
    .count_o     (w_count),
    .head_o      (w_head)
  );

  assign imem_en_o   = w_issue;
  assign imem_addr_o = w_fetch_addr;
  assign valid_o     = w_valid;
  assign instr_o     = w_head.instr;
  assign addr_o      = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_instr_fetch : directed vector table plus randomized model check    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_instr_fetch;

  localparam logic [31:0] C_SALT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_tgt_i = '0;
  logic        ready_i = 1'b1;
  logic        imem_en_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i = '0;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] addr_o;

  int tests = 0;
  int fails = 0;

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_i     (redirect_i),
    .redirect_tgt_i (redirect_tgt_i),
    .ready_i        (ready_i),
    .imem_en_o      (imem_en_o),
    .imem_addr_o    (imem_addr_o),
    .imem_rdata_i   (imem_rdata_i),
    .valid_o        (valid_o),
    .instr_o        (instr_o),
    .addr_o         (addr_o)
  );

  always #5 clk = ~clk;

  // Synchronous memory: one-cycle latency, content derived from address.
  always @(posedge clk)
    imem_rdata_i <= imem_en_o ? (imem_addr_o ^ C_SALT) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        redirect;
    logic [31:0] tgt;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic        exp_en;
    logic [31:0] exp_imem_addr;
  } vec_t;

  vec_t vec [23];

  int          age;
  logic [31:0] exp_addr;
  logic        rnd_red;
  logic        exp_v;

  initial begin
    // cycle 0 is the first cycle after reset release
    vec[0]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0};
    vec[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h4};
    vec[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 32'h8};
    vec[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         1'b1, 32'hC};
    vec[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         1'b0, 32'h0};
    vec[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         1'b0, 32'h0};
    vec[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         1'b0, 32'h0};
    vec[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         1'b0, 32'h0};
    vec[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         1'b0, 32'h0};
    vec[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         1'b1, 32'h10};
    vec[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         1'b1, 32'h14};
    vec[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h10,        1'b1, 32'h18};
    vec[12] = '{1'b1, 32'h103,       1'b1, 1'b0, 32'h0,         1'b1, 32'h100};
    vec[13] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h104};
    vec[14] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h100,       1'b1, 32'h108};
    vec[15] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h104,       1'b1, 32'h10C};
    vec[16] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h108,       1'b0, 32'h0};
    vec[17] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h108,       1'b0, 32'h0};
    vec[18] = '{1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFF8};
    vec[19] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC};
    vec[20] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h0};
    vec[21] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h4};
    vec[22] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 32'h8};

    // Held in reset with ready high: nothing may be requested or presented.
    repeat (3) @(negedge clk);
    #1;
    check("reset_valid", {31'b0, valid_o}, 32'h0);
    check("reset_instr", instr_o, 32'h0);
    check("reset_addr", addr_o, 32'h0);
    check("reset_en", {31'b0, imem_en_o}, 32'h0);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b0;
      redirect_i     = vec[i].redirect;
      redirect_tgt_i = vec[i].tgt;
      ready_i        = vec[i].ready;
      #1;
      check($sformatf("vec%0d_valid", i), {31'b0, valid_o}, {31'b0, vec[i].exp_valid});
      check($sformatf("vec%0d_en", i), {31'b0, imem_en_o}, {31'b0, vec[i].exp_en});
      if (vec[i].exp_en)
        check($sformatf("vec%0d_imem_addr", i), imem_addr_o, vec[i].exp_imem_addr);
      if (vec[i].exp_valid) begin
        check($sformatf("vec%0d_addr", i), addr_o, vec[i].exp_addr);
        check($sformatf("vec%0d_instr", i), instr_o, vec[i].exp_addr ^ C_SALT);
      end
    end

    // Asynchronous reset between edges, mid-stream.
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, valid_o}, 32'h0);
    check("async_rst_instr", instr_o, 32'h0);
    check("async_rst_addr", addr_o, 32'h0);
    check("async_rst_en", {31'b0, imem_en_o}, 32'h0);
    redirect_i = 1'b0;
    repeat (2) @(negedge clk);

    // Random phase: expected stream is start, start+4, ... from each restart;
    // valid_o is high exactly from two cycles after a restart while no redirect.
    age      = 0;
    exp_addr = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b0;
      rnd_red        = (i > 0) && ($urandom_range(0, 19) == 0);
      redirect_i     = rnd_red;
      redirect_tgt_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      ready_i        = ($urandom_range(0, 9) < 7);
      #1;
      exp_v = !rnd_red && (age >= 2);
      if (valid_o !== exp_v)
        check("rnd_valid", {31'b0, valid_o}, {31'b0, exp_v});
      else
        tests++;
      if (rnd_red) begin
        check("rnd_redirect_en", {31'b0, imem_en_o}, 32'h1);
        check("rnd_redirect_addr", imem_addr_o, {redirect_tgt_i[31:2], 2'b00});
      end else if (imem_en_o) begin
        check("rnd_imem_align", {30'b0, imem_addr_o[1:0]}, 32'h0);
      end
      if (valid_o && ready_i) begin
        check("rnd_addr", addr_o, exp_addr);
        check("rnd_instr", instr_o, exp_addr ^ C_SALT);
      end
      if (rnd_red) begin
        exp_addr = {redirect_tgt_i[31:2], 2'b00};
        age      = 1;
      end else begin
        if (valid_o && ready_i) exp_addr = exp_addr + 32'd4;
        if (age < 2) age++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage, directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words in a 2-entry skid buffer so downstream stalls never lose an in-flight fetch.
- Presents {instr, pc} with a valid/ready handshake; a taken branch or jump redirects the PC and flushes stale fetches.

Parameters:
- XLEN, 32, instruction and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BUF_DEPTH, 2, skid-buffer entries. Fixed at 2; other values are unsupported.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-high reset (high = reset, despite the name).
- redirect_i  input  1  taken branch/jump this cycle.
- redirect_tgt_i  input  XLEN  redirect target; bits [1:0] ignored (treated as 00).
- ready_i  input  1  downstream accepts the output word (IF/ID not stalled).
- imem_en_o  output  1  fetch request this cycle.
- imem_addr_o  output  XLEN  fetch address, bits [1:0] always 00.
- imem_rdata_i  input  XLEN  instruction word, valid the cycle after imem_en_o.
- valid_o  output  1  instr_o/addr_o hold a valid fetched word.
- instr_o  output  XLEN  fetched instruction.
- addr_o  output  XLEN  PC of instr_o.

Behaviour:
- State:
  - pc_q: next sequential fetch address.
  - inflight_q: 1 bit, request issued last cycle.
  - buffer: 2 entries of {instr, pc}, with count 0..2.
- Reset (asynchronous, any time, including mid-fetch):
  - pc_q=RESET_PC, inflight_q=0, count=0, buffer pointers=0.
  - imem_en_o=0, valid_o=0, instr_o=0, addr_o=0.
  - First request issues the first cycle after reset deasserts.
- Output side:
  - valid_o = (count != 0) && !redirect_i.
  - instr_o/addr_o show the head entry; they are 0 when count == 0.
  - pop = valid_o && ready_i.
- Issue rule:
  - Without redirect, issue when (count + inflight_q - pop) < 2.
  - On issue: imem_en_o=1, imem_addr_o=pc_q, pc_q <= pc_q+4.
  - pc_q+4 wraps modulo 2^XLEN: 32'hFFFF_FFFC is followed by 0.
- Response:
  - When inflight_q=1 and no redirect, imem_rdata_i and its PC are pushed at the clock edge.
  - Each in-flight request carries its PC in a 1-deep address register.
  - Push and pop may occur in the same cycle; count is unchanged.
- Latency: issue in cycle t, data returns in t+1, valid_o in t+2. Steady-state throughput is 1 word/cycle with count=1 and inflight_q=1.
- Stall (ready_i=0):
  - Head is held stable and valid_o stays 1.
  - The in-flight word still lands, so count reaches 2.
  - Issue halts; no word is dropped or duplicated.
- Redirect (priority over stall and over everything except reset), in cycle t:
  - valid_o=0 combinationally.
  - Buffer is flushed (count <= 0).
  - Any imem_rdata_i returning in cycle t is discarded.
  - imem_en_o=1 with imem_addr_o = {redirect_tgt_i[XLEN-1:2],2'b00}; pc_q <= that value + 4.
  - Target word reaches valid_o in cycle t+2.
  - Back-to-back redirects: each cycle's redirect wins; the earlier target's response is discarded.
- Buffer wrap: read and write pointers are 1 bit and toggle. Full (count=2) and empty (count=0) are tracked by count.
- Invariant: count + inflight_q ≤ 2 at every clock edge. Push is never attempted while full.

Decomposition:
- Shared package cpu_pkg:
  - XLEN.
  - RESET_PC default.
  - INSTR_BYTES=4.
  - fetch_entry_t = struct {instr, pc}.
- Sub-module fetch_skid_buf: 2-entry FIFO of fetch_entry_t with push, pop, flush, count, head.
- instr_fetch keeps the PC, issue and credit logic, and redirect handling.

Test Plan:
- Reset then ready_i=1, imem returning word = addr ^ 32'hA5A5_0000:
  - imem_addr_o = 0, 4, 8, ….
  - valid_o first high 2 cycles after first issue, with addr_o=0 and instr_o=32'hA5A5_0000.
  - One word every cycle thereafter.
- Stall: hold ready_i=0 for 5 cycles while streaming:
  - count reaches 2 and imem_en_o drops.
  - On release, addr_o continues 8, C, 10, … with no gap-induced loss or duplicate.
- Redirect to 32'h0000_0103 while a fetch is in flight:
  - imem_addr_o=32'h100 that cycle and valid_o=0.
  - Stale word dropped.
  - Next valid_o shows addr_o=32'h100, then 32'h104.
- Redirect asserted together with ready_i=0 and buffer full: buffer flushed, target fetched, no old PC ever appears on addr_o.
- Wrap: redirect to 32'hFFFF_FFF8 → addr_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst_n asynchronously mid-stream (between clock edges):
  - valid_o, instr_o and addr_o go to 0 immediately.
  - After release, fetching restarts at RESET_PC.
